// File: rtl/param_updown_step2_counter.sv
// Up/down counter stepping by 2 through the even or odd values of a WIDTH-bit register.
// Parity bit tracks 'odd' every edge; the upper bits form the step index.
module param_updown_step2_counter #(
    parameter int   WIDTH   = 4,
    parameter logic RST_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             y,
    input  logic             odd,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam int IW = WIDTH - 1;
    localparam logic [IW-1:0] IMAX = '1;

    logic [IW-1:0] idx_q, idx_d;
    logic          par_q, par_d;
    logic          wrap_q, wrap_d;
    logic          at_top, at_bot;

    assign at_top = (idx_q == IMAX);
    assign at_bot = (idx_q == '0);

    always_comb begin
        idx_d  = idx_q;
        par_d  = odd;
        wrap_d = 1'b0;
        if (load) begin
            idx_d = load_val[WIDTH-1:1];
        end else if (en) begin
            if (!y) begin
                if (!at_top) begin
                    idx_d = idx_q + 1'b1;
                end else if (!sat) begin
                    idx_d  = '0;
                    wrap_d = 1'b1;
                end
            end else begin
                if (!at_bot) begin
                    idx_d = idx_q - 1'b1;
                end else if (!sat) begin
                    idx_d  = IMAX;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q  <= '0;
            par_q  <= RST_ODD;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            par_q  <= par_d;
            wrap_q <= wrap_d;
        end
    end

    // tc looks at the live direction input so a y change shows up within the cycle.
    assign tc   = (!y && at_top) || (y && at_bot);
    assign q    = {idx_q, par_q};
    assign wrap = wrap_q;

endmodule

// File: tb/tb_param_updown_step2_counter.sv
// Directed bench for param_updown_step2_counter: even DUT (RST_ODD=0) and odd-reset DUT (RST_ODD=1).
module tb_param_updown_step2_counter;

    logic       clk = 1'b0;
    logic       reset, en, y, odd, sat, load;
    logic [3:0] load_val;
    logic [3:0] q;
    logic       tc, wrap;

    logic       reset2, en2, y2, odd2, sat2, load2;
    logic [3:0] load_val2;
    logic [3:0] q2;
    logic       tc2, wrap2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    param_updown_step2_counter #(.WIDTH(4), .RST_ODD(1'b0)) u_dut (
        .clk(clk), .reset(reset), .en(en), .y(y), .odd(odd), .sat(sat),
        .load(load), .load_val(load_val), .q(q), .tc(tc), .wrap(wrap)
    );

    param_updown_step2_counter #(.WIDTH(4), .RST_ODD(1'b1)) u_dut_odd (
        .clk(clk), .reset(reset2), .en(en2), .y(y2), .odd(odd2), .sat(sat2),
        .load(load2), .load_val(load_val2), .q(q2), .tc(tc2), .wrap(wrap2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; y = 1'b0; odd = 1'b0; sat = 1'b0;
        load = 1'b0; load_val = 4'd0;
        reset2 = 1'b1; en2 = 1'b0; y2 = 1'b0; odd2 = 1'b1; sat2 = 1'b0;
        load2 = 1'b0; load_val2 = 4'd0;
        step();
        n_cmp++;
        if (q !== 4'd0) begin n_err++; $display("FAIL reset_q: got %0d want 0", q); end
        n_cmp++;
        if (wrap !== 1'b0) begin n_err++; $display("FAIL reset_wrap: got %b want 0", wrap); end
        n_cmp++;
        if (tc !== 1'b0) begin n_err++; $display("FAIL reset_tc: got %b want 0", tc); end
        reset = 1'b0;
    endtask

    task automatic test_wrap_up();
        logic [3:0] eq [0:7];
        logic       etc [0:7];
        logic       ewr [0:7];
        eq  = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14, 4'd0};
        etc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        ewr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if (q !== eq[i] || tc !== etc[i] || wrap !== ewr[i]) begin
                n_err++;
                $display("FAIL wrap_up[%0d]: got q=%0d tc=%b wrap=%b want q=%0d tc=%b wrap=%b",
                         i, q, tc, wrap, eq[i], etc[i], ewr[i]);
            end
        end
    endtask

    task automatic test_wrap_down();
        logic [3:0] eq [0:2];
        logic       etc [0:2];
        logic       ewr [0:2];
        eq  = '{4'd2, 4'd0, 4'd14};
        etc = '{1'b0, 1'b1, 1'b0};
        ewr = '{1'b0, 1'b0, 1'b1};
        load = 1'b1; load_val = 4'd4;
        step();
        load = 1'b0;
        n_cmp++;
        if (q !== 4'd4) begin n_err++; $display("FAIL down_load: got %0d want 4", q); end
        y = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (q !== eq[i] || tc !== etc[i] || wrap !== ewr[i]) begin
                n_err++;
                $display("FAIL wrap_down[%0d]: got q=%0d tc=%b wrap=%b want q=%0d tc=%b wrap=%b",
                         i, q, tc, wrap, eq[i], etc[i], ewr[i]);
            end
        end
        y = 1'b0;
        #1;
        n_cmp++;
        if (tc !== 1'b1) begin n_err++; $display("FAIL dir_change_tc: got %b want 1", tc); end
        step();
        n_cmp++;
        if (q !== 4'd0 || wrap !== 1'b1) begin
            n_err++; $display("FAIL dir_change: got q=%0d wrap=%b want q=0 wrap=1", q, wrap);
        end
    endtask

    task automatic test_saturate();
        load = 1'b1; load_val = 4'd12; sat = 1'b1; y = 1'b0;
        step();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (q !== 4'd14 || wrap !== 1'b0 || tc !== 1'b1) begin
                n_err++;
                $display("FAIL sat_up[%0d]: got q=%0d tc=%b wrap=%b want q=14 tc=1 wrap=0", i, q, tc, wrap);
            end
        end
        y = 1'b1;
        #1;
        n_cmp++;
        if (tc !== 1'b0) begin n_err++; $display("FAIL sat_tc_y: got %b want 0", tc); end
        step();
        n_cmp++;
        if (q !== 4'd12) begin n_err++; $display("FAIL sat_back: got %0d want 12", q); end
        load = 1'b1; load_val = 4'd0;
        step();
        load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (q !== 4'd0 || wrap !== 1'b0 || tc !== 1'b1) begin
                n_err++;
                $display("FAIL sat_down[%0d]: got q=%0d tc=%b wrap=%b want q=0 tc=1 wrap=0", i, q, tc, wrap);
            end
        end
        sat = 1'b0;
    endtask

    task automatic test_load_hold_parity();
        load = 1'b1; load_val = 4'b0111; odd = 1'b0; en = 1'b1; y = 1'b0;
        step();
        load = 1'b0;
        n_cmp++;
        if (q !== 4'd6) begin n_err++; $display("FAIL load_bit0: got %0d want 6", q); end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (q !== 4'd6) begin n_err++; $display("FAIL hold[%0d]: got %0d want 6", i, q); end
        end
        odd = 1'b1; en = 1'b1; y = 1'b0;
        step();
        n_cmp++;
        if (q !== 4'd9) begin n_err++; $display("FAIL parity_step: got %0d want 9", q); end
        load = 1'b1; load_val = 4'd10; odd = 1'b0; y = 1'b1;
        step();
        load = 1'b0; y = 1'b0;
        n_cmp++;
        if (q !== 4'd10) begin n_err++; $display("FAIL load_wins: got %0d want 10", q); end
    endtask

    task automatic test_async_reset();
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (q !== 4'd0 || wrap !== 1'b0) begin
            n_err++; $display("FAIL async_reset: got q=%0d wrap=%b want q=0 wrap=0", q, wrap);
        end
        reset = 1'b0;
        step();
        n_cmp++;
        if (q !== 4'd2) begin n_err++; $display("FAIL after_reset: got %0d want 2", q); end
        load = 1'b1; load_val = 4'd14;
        step();
        load = 1'b0;
        step();
        n_cmp++;
        if (q !== 4'd0 || wrap !== 1'b1) begin
            n_err++; $display("FAIL pre_reset_wrap: got q=%0d wrap=%b want q=0 wrap=1", q, wrap);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (wrap !== 1'b0) begin n_err++; $display("FAIL async_reset_wrap: got %b want 0", wrap); end
        reset = 1'b0;
    endtask

    task automatic test_odd_reset();
        logic [3:0] eq [0:7];
        logic       etc [0:7];
        logic       ewr [0:7];
        eq  = '{4'd3, 4'd5, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15, 4'd1};
        etc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        ewr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        #1;
        n_cmp++;
        if (q2 !== 4'd1 || wrap2 !== 1'b0) begin
            n_err++; $display("FAIL odd_reset: got q=%0d wrap=%b want q=1 wrap=0", q2, wrap2);
        end
        en2 = 1'b1; odd2 = 1'b1; y2 = 1'b0; sat2 = 1'b0;
        reset2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if (q2 !== eq[i] || tc2 !== etc[i] || wrap2 !== ewr[i]) begin
                n_err++;
                $display("FAIL odd_up[%0d]: got q=%0d tc=%b wrap=%b want q=%0d tc=%b wrap=%b",
                         i, q2, tc2, wrap2, eq[i], etc[i], ewr[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_load_hold_parity();
        test_async_reset();
        test_odd_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
